// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: input conditioning, IDLE/RUN/PAUSE/DONE sequencing, tick prescaler.
// Optional lap/freeze output enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int DIV_BITS  = 20,
  parameter int DB_CYCLES = 1000000,
  parameter int DB_BITS   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       sw_dir,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic       freeze,
`endif
  input  logic       count_done,
  output logic       tick,
  output logic       up_down,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int I_START = 0;
  localparam int I_CLEAR = 1;
  localparam int I_DIR   = 2;
`ifdef STOPWATCH_LAP_EN
  localparam int I_LAP   = 3;
  localparam int N_IN    = 4;
`else
  localparam int N_IN    = 3;
`endif

  localparam logic [DB_BITS-1:0]  DB_LAST  = DB_BITS'(DB_CYCLES - 1);
  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  logic [N_IN-1:0]              raw;
  logic [N_IN-1:0]              sync_p0;
  logic [N_IN-1:0]              sync_p1;
  logic [N_IN-1:0]              deb;
  logic [N_IN-1:0]              deb_q;
  logic [N_IN-1:0][DB_BITS-1:0] db_cnt;

  state_t              st;
  logic [DIV_BITS-1:0] presc;
  logic                dir_pend;

  logic press_start;
  logic press_clear;
  logic dir_chg;
`ifdef STOPWATCH_LAP_EN
  logic press_lap;

  assign raw = {btn_lap, sw_dir, btn_clear, btn_start_stop};
`else
  assign raw = {sw_dir, btn_clear, btn_start_stop};
`endif

  // Stage p0/p1: two-flop synchroniser for every raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb    <= '0;
      deb_q  <= '0;
      db_cnt <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < N_IN; i++) begin
        if (sync_p1[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press_start = deb[I_START] & ~deb_q[I_START];
  assign press_clear = deb[I_CLEAR] & ~deb_q[I_CLEAR];
  assign dir_chg     = deb[I_DIR] ^ deb_q[I_DIR];
`ifdef STOPWATCH_LAP_EN
  assign press_lap   = deb[I_LAP] & ~deb_q[I_LAP];
`endif

  // Direction is loaded on a debounced switch change; a change seen outside IDLE
  // stays pending so it takes effect once the stopwatch is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      presc    <= '0;
      up_down  <= 1'b1;
      cnt_clr  <= 1'b0;
      running  <= 1'b0;
      dir_pend <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      freeze   <= 1'b0;
`endif
    end else begin
      cnt_clr <= 1'b0;
      if (dir_chg) dir_pend <= 1'b1;
      if (press_clear) begin
        st      <= IDLE;
        presc   <= '0;
        cnt_clr <= 1'b1;
        running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
        freeze  <= 1'b0;
`endif
      end else begin
        case (st)
          IDLE: begin
            presc <= '0;
            if (dir_chg || dir_pend) begin
              up_down  <= deb[I_DIR];
              dir_pend <= 1'b0;
              if (deb[I_DIR] != up_down) cnt_clr <= 1'b1;
            end
            if (press_start) begin
              st      <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (!up_down && count_done) begin
              st      <= DONE;
              running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
              freeze  <= 1'b0;
`endif
            end else begin
`ifdef STOPWATCH_LAP_EN
              if (press_lap) freeze <= ~freeze;
`endif
              if (press_start) begin
                st      <= PAUSE;
                running <= 1'b0;
              end else begin
                presc <= (presc == DIV_LAST) ? '0 : presc + 1'b1;
              end
            end
          end
          PAUSE: begin
`ifdef STOPWATCH_LAP_EN
            if (press_lap) freeze <= ~freeze;
`endif
            if (press_start) begin
              st      <= RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state = st;
  assign tick  = (st == RUN) && (presc == DIV_LAST) && !(count_done && !up_down);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3 (default build, no lap feature).
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       sw_dir = 1'b1;
  logic       count_done = 1'b0;
  logic       tick;
  logic       up_down;
  logic       cnt_clr;
  logic       running;
  logic [1:0] state;

  stopwatch_ctrl #(
    .TICK_DIV  (4),
    .DIV_BITS  (3),
    .DB_CYCLES (3),
    .DB_BITS   (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .sw_dir         (sw_dir),
    .count_done     (count_done),
    .tick           (tick),
    .up_down        (up_down),
    .cnt_clr        (cnt_clr),
    .running        (running),
    .state          (state)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  int   tick_cnt = 0, clr_cnt = 0, tick_dbl = 0, clr_dbl = 0, tick_bad = 0;
  logic tick_q = 1'b0, clr_q = 1'b0;

  // Event monitor, sampled 3 ns after each rising edge
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      if (tick) tick_cnt++;
      if (cnt_clr) clr_cnt++;
      if (tick && tick_q) tick_dbl++;
      if (cnt_clr && clr_q) clr_dbl++;
      if (tick && state != S_RUN) tick_bad++;
      tick_q = tick;
      clr_q  = cnt_clr;
    end
  end

  typedef struct {
    logic       st;
    logic       cl;
    logic       dir;
    logic       done;
    int         hold;
    logic [1:0] e_state;
    logic       e_ud;
    logic       e_run;
    int         e_clr;
    int         e_tick;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #4;
      cyc_n++;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm, output int n);
    n = 0;
    while (state !== s && n < 16) begin
      cyc(1);
      n++;
    end
    chk(nm, state, s);
  endtask

  task automatic wait_tick(input string nm, output int n);
    n = 0;
    while (tick !== 1'b1 && n < 8) begin
      cyc(1);
      n++;
    end
    chk(nm, tick, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int n, e, last, nt, c0, t0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, S_IDLE,  1'b0, 1'b0, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,  8, S_RUN,   1'b0, 1'b1, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,  8, S_RUN,   1'b0, 1'b1, 0, 2};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1,  3, S_DONE,  1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10, S_DONE,  1'b0, 1'b0, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, S_DONE,  1'b0, 1'b0, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, S_IDLE,  1'b0, 1'b0, 1, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, S_IDLE,  1'b1, 1'b0, 1, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1,  8, S_RUN,   1'b1, 1'b1, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1,  8, S_RUN,   1'b1, 1'b1, 0, 2};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, S_IDLE,  1'b1, 1'b0, 1, 2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 10, S_IDLE,  1'b1, 1'b0, 0, 0};

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      btn_start_stop = 1'($urandom_range(0, 1));
      btn_clear      = 1'($urandom_range(0, 1));
      sw_dir         = 1'($urandom_range(0, 1));
      count_done     = 1'($urandom_range(0, 1));
      cyc(1);
    end
    chk("reset state", state, S_IDLE);
    chk("reset tick", tick, 0);
    chk("reset up_down", up_down, 1);
    chk("reset cnt_clr", cnt_clr, 0);
    chk("reset running", running, 0);

    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    sw_dir         = 1'b1;
    count_done     = 1'b0;
    cyc(1);
    rst = 1'b0;
    c0 = clr_cnt;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (state !== S_IDLE || up_down !== 1'b1 || tick !== 1'b0 || running !== 1'b0) n++;
    end
    chk("idle after reset unchanged", n, 0);
    chk("idle after reset cnt_clr pulses", clr_cnt - c0, 0);

    // Bounce rejection
    for (int i = 0; i < 10; i++) begin
      btn_start_stop = 1'b1;
      cyc(2);
      btn_start_stop = 1'b0;
      cyc(1);
    end
    cyc(8);
    chk("bounce state", state, S_IDLE);
    chk("bounce running", running, 0);

    // Start and tick cadence
    btn_start_stop = 1'b1;
    wait_state(S_RUN, "start reaches RUN", n);
    chk("start latency within 7", (n >= 1 && n <= 7), 1);
    chk("running in RUN", running, 1);
    e = cyc_n;
    last = -1;
    nt = 0;
    for (int k = 1; k <= 28; k++) begin
      if (k == 10 - n) btn_start_stop = 1'b0;
      cyc(1);
      if (tick) begin
        if (last < 0) chk("first tick offset", cyc_n - e, 3);
        else chk("tick period", cyc_n - last, 4);
        last = cyc_n;
        nt++;
      end
    end
    btn_start_stop = 1'b0;
    chk("tick count over 28 cycles", nt, 7);

    // Pause with prescaler at 2, then resume
    wait_tick("tick before pause", n);
    cyc(2);
    btn_start_stop = 1'b1;
    wait_state(S_PAUSE, "pause reached", n);
    chk("pause entry delay", n, 6);
    chk("no tick on pause entry", tick, 0);
    cyc(2);
    btn_start_stop = 1'b0;
    cyc(10);
    chk("pause held", state, S_PAUSE);
    chk("running low in pause", running, 0);
    btn_start_stop = 1'b1;
    wait_state(S_RUN, "resume reached", n);
    chk("no tick at resume entry", tick, 0);
    cyc(1);
    chk("tick one cycle after resume", tick, 1);
    cyc(5);
    btn_start_stop = 1'b0;
    cyc(10);

    // Clear and start in the same cycle while paused
    btn_start_stop = 1'b1;
    wait_state(S_PAUSE, "second pause reached", n);
    cyc(3);
    btn_start_stop = 1'b0;
    cyc(10);
    c0 = clr_cnt;
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    wait_state(S_IDLE, "clear priority to IDLE", n);
    chk("clear priority cnt_clr high", cnt_clr, 1);
    cyc(1);
    chk("clear priority cnt_clr one cycle", cnt_clr, 0);
    cyc(4);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    cyc(10);
    chk("clear priority pulse count", clr_cnt - c0, 1);
    chk("clear priority stays IDLE", state, S_IDLE);
    btn_start_stop = 1'b1;
    wait_state(S_RUN, "restart after clear", n);
    wait_tick("tick after restart", n);
    chk("prescaler restarted from 0", n, 3);
    btn_start_stop = 1'b0;
    cyc(10);
    btn_clear = 1'b1;
    cyc(8);
    btn_clear = 1'b0;
    cyc(10);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      btn_start_stop = vecs[i].st;
      btn_clear      = vecs[i].cl;
      sw_dir         = vecs[i].dir;
      count_done     = vecs[i].done;
      c0 = clr_cnt;
      t0 = tick_cnt;
      cyc(vecs[i].hold);
      chk($sformatf("row%0d state", i), state, vecs[i].e_state);
      chk($sformatf("row%0d up_down", i), up_down, vecs[i].e_ud);
      chk($sformatf("row%0d running", i), running, vecs[i].e_run);
      chk($sformatf("row%0d cnt_clr pulses", i), clr_cnt - c0, vecs[i].e_clr);
      if (vecs[i].e_tick >= 0) chk($sformatf("row%0d ticks", i), tick_cnt - t0, vecs[i].e_tick);
    end
    count_done = 1'b0;

    // Count-down completion coinciding with the tick phase
    sw_dir = 1'b0;
    cyc(10);
    chk("count-down up_down", up_down, 0);
    btn_start_stop = 1'b1;
    wait_state(S_RUN, "count-down run", n);
    cyc(2);
    btn_start_stop = 1'b0;
    cyc(8);
    wait_tick("count-down tick", n);
    cyc(3);
    @(posedge clk);
    #1;
    count_done = 1'b1;
    #1;
    chk("tick suppressed by count_done", tick, 0);
    chk("still RUN before done edge", state, S_RUN);
    #2;
    cyc(1);
    chk("DONE after count_done", state, S_DONE);
    chk("no tick in DONE", tick, 0);
    count_done = 1'b0;
    btn_clear = 1'b1;
    cyc(8);
    btn_clear = 1'b0;
    cyc(10);
    chk("clear from DONE", state, S_IDLE);

    chk("tick never two cycles wide", tick_dbl, 0);
    chk("cnt_clr never two cycles wide", clr_dbl, 0);
    chk("tick only in RUN", tick_bad, 0);

    // Asynchronous reset in the middle of a run
    btn_start_stop = 1'b1;
    wait_state(S_RUN, "run before async reset", n);
    rst = 1'b1;
    #1;
    chk("async reset state", state, S_IDLE);
    chk("async reset running", running, 0);
    chk("async reset up_down", up_down, 1);
    chk("async reset cnt_clr", cnt_clr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
